// File: rtl/reg16_serial_tx_if.sv
// Handshake bundle for reg16_serial_tx: load strobe and word in, serial line and status out.
interface reg16_serial_tx_if;
    logic        load_en;
    logic [15:0] reg_in;
    logic        ser_out;
    logic        busy;
    logic        done;

    modport master (
        output load_en,
        output reg_in,
        input  ser_out,
        input  busy,
        input  done
    );

    modport slave (
        input  load_en,
        input  reg_in,
        output ser_out,
        output busy,
        output done
    );
endinterface

// File: rtl/reg16_serial_tx.sv
// Serial transmitter for 16-bit register words: start bit, 16 data bits LSB-first, stop bit.
// Define REG16_TX_PARITY_EN to add an even-parity bit between the data and the stop bit.
module reg16_serial_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    reg16_serial_tx_if.slave bus
);

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef REG16_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        ser_q, ser_d;
    logic        done_q, done_d;
`ifdef REG16_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    logic bitEnd;
    assign bitEnd = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= 16'h0000;
            cnt_q   <= 8'h00;
            idx_q   <= 4'h0;
            ser_q   <= 1'b1;
            done_q  <= 1'b0;
`ifdef REG16_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
`ifdef REG16_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // ser_d is the line level for the state being entered, so the registered
    // output changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ser_d   = 1'b1;
        done_d  = 1'b0;
`ifdef REG16_TX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.load_en) begin
                    state_d = START;
                    shift_d = bus.reg_in;
                    cnt_d   = 8'h00;
                    idx_d   = 4'h0;
                    ser_d   = 1'b0;
`ifdef REG16_TX_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end

            START: begin
                if (bitEnd) begin
                    state_d = DATA;
                    cnt_d   = 8'h00;
                    ser_d   = shift_q[0];
                end else begin
                    cnt_d   = cnt_q + 8'h01;
                    ser_d   = 1'b0;
                end
            end

            DATA: begin
                if (bitEnd) begin
                    cnt_d   = 8'h00;
                    shift_d = {1'b0, shift_q[15:1]};
                    idx_d   = idx_q + 4'h1;
`ifdef REG16_TX_PARITY_EN
                    par_d   = par_q ^ shift_q[0];
`endif
                    if (idx_q == 4'hF) begin
`ifdef REG16_TX_PARITY_EN
                        state_d = PARITY;
                        ser_d   = par_q ^ shift_q[0];
`else
                        state_d = STOP;
                        ser_d   = 1'b1;
`endif
                    end else begin
                        ser_d   = shift_q[1];
                    end
                end else begin
                    cnt_d   = cnt_q + 8'h01;
                    ser_d   = shift_q[0];
                end
            end

`ifdef REG16_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    state_d = STOP;
                    cnt_d   = 8'h00;
                    ser_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'h01;
                    ser_d   = par_q;
                end
            end
`endif

            STOP: begin
                if (bitEnd) begin
                    cnt_d = 8'h00;
                    // A load on the final stop-bit edge chains straight into the next
                    // start bit; there is no IDLE cycle, so done stays low then.
                    if (bus.load_en) begin
                        state_d = START;
                        shift_d = bus.reg_in;
                        idx_d   = 4'h0;
                        ser_d   = 1'b0;
`ifdef REG16_TX_PARITY_EN
                        par_d   = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        ser_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'h01;
                    ser_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 8'h00;
                idx_d   = 4'h0;
                ser_d   = 1'b1;
            end
        endcase
    end

    assign bus.ser_out = ser_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_reg16_serial_tx.sv
// Directed bench for reg16_serial_tx: three instances (4, 2 and 1 clocks per bit) checked against a bit-level scoreboard.
module tb_reg16_serial_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int errors = 0;
    int checks = 0;

    logic expQ[$];

`ifdef REG16_TX_PARITY_EN
    localparam int NB = 19;
`else
    localparam int NB = 18;
`endif

    reg16_serial_tx_if ifA ();
    reg16_serial_tx_if ifB ();
    reg16_serial_tx_if ifC ();

    reg16_serial_tx #(.CLKS_PER_BIT(4)) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
    reg16_serial_tx #(.CLKS_PER_BIT(2)) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));
    reg16_serial_tx #(.CLKS_PER_BIT(1)) dutC (.clk(clk), .rst(rst), .bus(ifC.slave));

    always #5 clk = ~clk;

    function automatic int clksOf(int sel);
        if (sel == 0) return 4;
        if (sel == 1) return 2;
        return 1;
    endfunction

    function automatic logic [2:0] outsOf(int sel);
        if (sel == 0) return {ifA.ser_out, ifA.busy, ifA.done};
        if (sel == 1) return {ifB.ser_out, ifB.busy, ifB.done};
        return {ifC.ser_out, ifC.busy, ifC.done};
    endfunction

    task automatic setLoad(int sel, logic en, logic [15:0] w);
        if (sel == 0) begin ifA.load_en = en; ifA.reg_in = w; end
        else if (sel == 1) begin ifB.load_en = en; ifB.reg_in = w; end
        else begin ifC.load_en = en; ifC.reg_in = w; end
    endtask

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushFrame(logic [15:0] w);
        expQ.push_back(1'b0);
        for (int i = 0; i < 16; i++) expQ.push_back(w[i]);
`ifdef REG16_TX_PARITY_EN
        expQ.push_back(^w);
`endif
        expQ.push_back(1'b1);
    endtask

    // Drives a load so that it is sampled at the next rising edge (edge k).
    task automatic applyStimulus(int sel, logic [15:0] w);
        @(negedge clk);
        setLoad(sel, 1'b1, w);
        pushFrame(w);
        @(posedge clk);
    endtask

    // Cycle m is the interval after edge k+m; a load driven in cycle m is sampled at edge k+m+1.
    task automatic checkFrame(int sel, string tag, int busyAt, logic [15:0] busyWord,
                              bit chain, logic [15:0] nextWord, int abortAt);
        int c;
        logic curBit;
        logic [2:0] o;
        c = clksOf(sel);
        curBit = 1'b1;
        for (int m = 0; m < NB * c; m++) begin
            @(negedge clk);
            if (m % c == 0) begin
                if (expQ.size() == 0) begin
                    checkOutput({tag, "_qempty"}, 32'd1, 32'd0);
                    curBit = 1'b1;
                end else begin
                    curBit = expQ.pop_front();
                end
            end
            o = outsOf(sel);
            checkOutput($sformatf("%s_ser_c%0d", tag, m), {31'd0, o[2]}, {31'd0, curBit});
            checkOutput($sformatf("%s_busy_c%0d", tag, m), {31'd0, o[1]}, 32'd1);
            checkOutput($sformatf("%s_done_c%0d", tag, m), {31'd0, o[0]}, 32'd0);
            setLoad(sel, 1'b0, 16'h0000);
            if (m == busyAt) setLoad(sel, 1'b1, busyWord);
            if (chain && m == NB * c - 1) begin
                setLoad(sel, 1'b1, nextWord);
                pushFrame(nextWord);
            end
            if (m == abortAt) return;
        end
        if (!chain) begin
            @(negedge clk);
            o = outsOf(sel);
            checkOutput({tag, "_end_ser"}, {31'd0, o[2]}, 32'd1);
            checkOutput({tag, "_end_busy"}, {31'd0, o[1]}, 32'd0);
            checkOutput({tag, "_end_done"}, {31'd0, o[0]}, 32'd1);
            @(negedge clk);
            o = outsOf(sel);
            checkOutput({tag, "_post_done"}, {31'd0, o[0]}, 32'd0);
            checkOutput({tag, "_post_busy"}, {31'd0, o[1]}, 32'd0);
            checkOutput({tag, "_post_ser"}, {31'd0, o[2]}, 32'd1);
        end
    endtask

    initial begin
        int bad;
        logic [2:0] o;
        setLoad(0, 1'b0, 16'h0000);
        setLoad(1, 1'b0, 16'h0000);
        setLoad(2, 1'b0, 16'h0000);

        $display("[TB] reset between edges");
        #7 rst = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            o = outsOf(s);
            checkOutput($sformatf("rst_ser_%0d", s), {31'd0, o[2]}, 32'd1);
            checkOutput($sformatf("rst_busy_%0d", s), {31'd0, o[1]}, 32'd0);
            checkOutput($sformatf("rst_done_%0d", s), {31'd0, o[0]}, 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        bad = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                o = outsOf(s);
                if (o !== 3'b100) bad++;
            end
        end
        checkOutput("idle_hold_50", bad, 0);

        $display("[TB] single frame 0xA5C3");
        applyStimulus(0, 16'hA5C3);
        checkFrame(0, "single", -1, 16'h0000, 1'b0, 16'h0000, -1);

        $display("[TB] load while busy");
        applyStimulus(0, 16'h1234);
        checkFrame(0, "busyload", 9, 16'hFFFF, 1'b0, 16'h0000, -1);

        $display("[TB] back-to-back frames");
        applyStimulus(1, 16'h0001);
        checkFrame(1, "b2b_first", -1, 16'h0000, 1'b1, 16'h8000, -1);
        checkFrame(1, "b2b_second", -1, 16'h0000, 1'b0, 16'h0000, -1);

        $display("[TB] one clock per bit");
        applyStimulus(2, 16'h5A5A);
        checkFrame(2, "c1", -1, 16'h0000, 1'b0, 16'h0000, -1);

`ifdef REG16_TX_PARITY_EN
        $display("[TB] parity frames");
        applyStimulus(0, 16'h0001);
        checkFrame(0, "par_odd", -1, 16'h0000, 1'b0, 16'h0000, -1);
        applyStimulus(0, 16'h0003);
        checkFrame(0, "par_even", -1, 16'h0000, 1'b0, 16'h0000, -1);
`endif

        $display("[TB] reset during data bit 7");
        applyStimulus(0, 16'h0000);
        checkFrame(0, "abort", -1, 16'h0000, 1'b0, 16'h0000, 33);
        #1 rst = 1'b1;
        #2;
        o = outsOf(0);
        checkOutput("abort_ser", {31'd0, o[2]}, 32'd1);
        checkOutput("abort_busy", {31'd0, o[1]}, 32'd0);
        checkOutput("abort_done", {31'd0, o[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        applyStimulus(0, 16'hBEEF);
        checkFrame(0, "after_rst", -1, 16'h0000, 1'b0, 16'h0000, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
